// File: rtl/uart_cmd_bridge.sv
// Bridges UART bytes and dig_core: packs three rx bytes into a 24-bit command and
// forwards single response bytes to the UART transmitter.
module uart_cmd_bridge #(
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp_data,
  output logic        resp_sent,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] RX_WAIT0 = 2'd0;
  localparam logic [1:0] RX_WAIT1 = 2'd1;
  localparam logic [1:0] RX_WAIT2 = 2'd2;
  localparam logic [1:0] RX_FULL  = 2'd3;

  localparam logic TX_IDLE = 1'b0;
  localparam logic TX_BUSY = 1'b1;

  logic [1:0]       r_rxState;
  logic [7:0]       r_byte0;
  logic [7:0]       r_byte1;
  logic [CNT_W-1:0] r_cnt;
  logic [23:0]      r_cmd;
  logic             r_cmdRdy;
  logic             r_txState;
  logic             r_trmt;
  logic [7:0]       r_txData;

  logic w_consume;
  logic w_expired;
  logic w_partial;

  assign w_partial  = (r_rxState == RX_WAIT1) || (r_rxState == RX_WAIT2);
  assign w_consume  = rx_rdy && (r_rxState != RX_FULL);
  assign w_expired  = w_partial && (r_cnt == CNT_LAST);

  assign clr_rx_rdy = w_consume;
  assign cmd        = r_cmd;
  assign cmd_rdy    = r_cmdRdy;
  assign trmt       = r_trmt;
  assign tx_data    = r_txData;
  // Pulses while still BUSY, so a send_resp in this same cycle is ignored.
  assign resp_sent  = (r_txState == TX_BUSY) && tx_done;

  // A byte arriving on the expiry cycle restarts the command as its first byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxState <= RX_WAIT0;
      r_byte0   <= '0;
      r_byte1   <= '0;
      r_cnt     <= '0;
      r_cmd     <= '0;
      r_cmdRdy  <= 1'b0;
    end else if (w_consume) begin
      r_cnt <= '0;
      if (w_expired || (r_rxState == RX_WAIT0)) begin
        r_byte0   <= rx_data;
        r_rxState <= RX_WAIT1;
      end else if (r_rxState == RX_WAIT1) begin
        r_byte1   <= rx_data;
        r_rxState <= RX_WAIT2;
      end else begin
        r_cmd     <= {r_byte0, r_byte1, rx_data};
        r_cmdRdy  <= 1'b1;
        r_rxState <= RX_FULL;
      end
    end else if (r_rxState == RX_FULL) begin
      r_cnt <= '0;
      if (clr_cmd_rdy) begin
        r_cmdRdy  <= 1'b0;
        r_rxState <= RX_WAIT0;
      end
    end else if (w_expired) begin
      r_cnt     <= '0;
      r_rxState <= RX_WAIT0;
    end else if (w_partial) begin
      if (r_cnt != '1) r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txState <= TX_IDLE;
      r_trmt    <= 1'b0;
      r_txData  <= '0;
    end else begin
      r_trmt <= 1'b0;
      if (r_txState == TX_IDLE) begin
        if (send_resp) begin
          r_txData  <= resp_data;
          r_trmt    <= 1'b1;
          r_txState <= TX_BUSY;
        end
      end else if (tx_done) begin
        r_txState <= TX_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge: command assembly, backpressure, inter-byte
// timeout, response transmit, mid-operation reset and simultaneous rx/tx activity.
module tb_uart_cmd_bridge;

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp_data;
  logic        resp_sent;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;

  int errors = 0;
  int checks = 0;
  int clrCount = 0;
  int trmtCount = 0;
  int respCount = 0;

  uart_cmd_bridge #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .resp_data(resp_data), .resp_sent(resp_sent),
    .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clr_rx_rdy) clrCount++;
    if (trmt) trmtCount++;
    if (resp_sent) respCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one byte and holds it until the bridge consumes it (bounded wait).
  task automatic applyStimulus(input logic [7:0] b);
    logic seen;
    seen = 1'b0;
    rx_rdy  = 1'b1;
    rx_data = b;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (clr_rx_rdy) seen = 1'b1;
    end
    checkOutput("rx_consume", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    rx_rdy = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearCmd();
    clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    int clrBefore;
    int respBefore;
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    send_resp = 1'b0; resp_data = 8'h00; tx_done = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_cmd", {8'd0, cmd}, 32'd0);
    checkOutput("reset_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    checkOutput("reset_trmt", {31'd0, trmt}, 32'd0);
    checkOutput("reset_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("reset_resp_sent", {31'd0, resp_sent}, 32'd0);
    checkOutput("reset_clr_rx_rdy", {31'd0, clr_rx_rdy}, 32'd0);
    rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] basic command assembly");
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    rx_rdy = 1'b1; rx_data = 8'h03;
    @(negedge clk);
    checkOutput("t1_third_pulse", {31'd0, clr_rx_rdy}, 32'd1);
    checkOutput("t1_rdy_not_yet", {31'd0, cmd_rdy}, 32'd0);
    @(posedge clk); #1; rx_rdy = 1'b0;
    @(negedge clk);
    checkOutput("t1_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    checkOutput("t1_cmd", {8'd0, cmd}, 32'h010203);
    checkOutput("t1_clr_count", clrCount, 32'd3);
    @(posedge clk); #1;
    clearCmd();
    @(negedge clk);
    checkOutput("t1_rdy_cleared", {31'd0, cmd_rdy}, 32'd0);
    checkOutput("t1_cmd_retained", {8'd0, cmd}, 32'h010203);

    $display("[TB] backpressure while full");
    @(posedge clk); #1;
    applyStimulus(8'h07);
    applyStimulus(8'h08);
    applyStimulus(8'h09);
    clrBefore = clrCount;
    rx_rdy = 1'b1; rx_data = 8'hAA;
    idleCycles(5);
    @(negedge clk);
    checkOutput("t2_no_consume", clrCount - clrBefore, 32'd0);
    checkOutput("t2_cmd_held", {8'd0, cmd}, 32'h070809);
    @(posedge clk); #1;
    clearCmd();
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    applyStimulus(8'hCC);
    @(negedge clk);
    checkOutput("t2_cmd", {8'd0, cmd}, 32'hAABBCC);
    checkOutput("t2_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    @(posedge clk); #1;
    clearCmd();

    $display("[TB] inter-byte timeout");
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    idleCycles(20);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    @(negedge clk);
    checkOutput("t3_discard_cmd", {8'd0, cmd}, 32'h334455);
    @(posedge clk); #1;
    clearCmd();
    applyStimulus(8'h61);
    idleCycles(14);
    applyStimulus(8'h62);
    idleCycles(14);
    applyStimulus(8'h63);
    @(negedge clk);
    checkOutput("t3_gap14_cmd", {8'd0, cmd}, 32'h616263);
    checkOutput("t3_gap14_rdy", {31'd0, cmd_rdy}, 32'd1);
    @(posedge clk); #1;
    clearCmd();
    applyStimulus(8'h71);
    idleCycles(15);
    applyStimulus(8'h72);
    applyStimulus(8'h73);
    @(negedge clk);
    checkOutput("t3_expiry_arrival_rdy", {31'd0, cmd_rdy}, 32'd0);
    @(posedge clk); #1;
    applyStimulus(8'h74);
    @(negedge clk);
    checkOutput("t3_expiry_arrival_cmd", {8'd0, cmd}, 32'h727374);
    @(posedge clk); #1;
    clearCmd();

    $display("[TB] response transmit");
    trmtCount = 0; respCount = 0;
    send_resp = 1'b1; resp_data = 8'hA5;
    @(negedge clk);
    checkOutput("t4_trmt_not_yet", {31'd0, trmt}, 32'd0);
    @(posedge clk); #1; send_resp = 1'b0; resp_data = 8'h00;
    @(negedge clk);
    checkOutput("t4_trmt", {31'd0, trmt}, 32'd1);
    checkOutput("t4_tx_data", {24'd0, tx_data}, 32'hA5);
    @(posedge clk); #1;
    send_resp = 1'b1; resp_data = 8'h3C;
    @(posedge clk); #1; send_resp = 1'b0;
    idleCycles(96);
    @(negedge clk);
    checkOutput("t4_single_trmt", trmtCount, 32'd1);
    checkOutput("t4_tx_data_stable", {24'd0, tx_data}, 32'hA5);
    checkOutput("t4_no_early_sent", respCount, 32'd0);
    @(posedge clk); #1;
    tx_done = 1'b1; send_resp = 1'b1; resp_data = 8'h5A;
    @(negedge clk);
    checkOutput("t4_resp_sent", {31'd0, resp_sent}, 32'd1);
    @(posedge clk); #1; tx_done = 1'b0; send_resp = 1'b0;
    @(negedge clk);
    checkOutput("t4_resp_pulse_len", {31'd0, resp_sent}, 32'd0);
    checkOutput("t4_send_in_sent_ignored", {31'd0, trmt}, 32'd0);
    idleCycles(3);
    @(negedge clk);
    checkOutput("t4_resp_count", respCount, 32'd1);
    checkOutput("t4_trmt_count", trmtCount, 32'd1);

    $display("[TB] simultaneous rx byte and send_resp");
    @(posedge clk); #1;
    applyStimulus(8'h81);
    applyStimulus(8'h82);
    rx_rdy = 1'b1; rx_data = 8'h83; send_resp = 1'b1; resp_data = 8'h99;
    @(negedge clk);
    checkOutput("t6_clr", {31'd0, clr_rx_rdy}, 32'd1);
    @(posedge clk); #1; rx_rdy = 1'b0; send_resp = 1'b0;
    @(negedge clk);
    checkOutput("t6_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    checkOutput("t6_cmd", {8'd0, cmd}, 32'h818283);
    checkOutput("t6_trmt", {31'd0, trmt}, 32'd1);
    checkOutput("t6_tx_data", {24'd0, tx_data}, 32'h99);
    @(posedge clk); #1;
    tx_done = 1'b1;
    @(posedge clk); #1; tx_done = 1'b0;
    clearCmd();

    $display("[TB] reset mid-operation");
    applyStimulus(8'h91);
    applyStimulus(8'h92);
    send_resp = 1'b1; resp_data = 8'h77;
    @(posedge clk); #1; send_resp = 1'b0;
    @(posedge clk); #1;
    respBefore = respCount;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_async_cmd", {8'd0, cmd}, 32'd0);
    checkOutput("t5_async_tx_data", {24'd0, tx_data}, 32'd0);
    @(negedge clk);
    checkOutput("t5_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    checkOutput("t5_trmt", {31'd0, trmt}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b1;
    @(negedge clk);
    checkOutput("t5_no_resp_sent", {31'd0, resp_sent}, 32'd0);
    @(posedge clk); #1; tx_done = 1'b0;
    applyStimulus(8'hA1);
    applyStimulus(8'hA2);
    applyStimulus(8'hA3);
    @(negedge clk);
    checkOutput("t5_fresh_cmd", {8'd0, cmd}, 32'hA1A2A3);
    checkOutput("t5_fresh_rdy", {31'd0, cmd_rdy}, 32'd1);
    checkOutput("t5_resp_count", respCount - respBefore, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
